// File: rtl/nvdla_dp_ram_ctrl_if.sv
// nvdla_dp_ram_ctrl_if: write, read-request and read-response streams between a requestor and nvdla_dp_ram_ctrl.
interface nvdla_dp_ram_ctrl_if #(
   parameter int AW = 8,
   parameter int DW = 64
) ();
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          rd_req_valid;
   logic          rd_req_ready;
   logic [AW-1:0] rd_req_addr;
   logic          rd_rsp_valid;
   logic          rd_rsp_ready;
   logic [DW-1:0] rd_rsp_data;

   modport master (
      output wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_rsp_ready,
      input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_req_valid, rd_req_addr, rd_rsp_ready,
      output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data
   );
endinterface

// File: rtl/nvdla_dp_ram_ctrl.sv
// nvdla_dp_ram_ctrl: arbitrates writes and reads onto a dual-port RAM (A=read, B=write) and buffers read data.
// Optional statistics counters are enabled by defining NVDLA_DP_RAM_CTRL_STATS_EN.
module nvdla_dp_ram_ctrl #(
   parameter int AW            = 8,
   parameter int DW            = 64,
   parameter int RSP_DEPTH     = 2,
   parameter int WR_STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                rst,
   nvdla_dp_ram_ctrl_if.slave  bus,
   output logic                ram_cena,
   output logic [AW-1:0]       ram_aa,
   input  logic [DW-1:0]       ram_qa,
   output logic                ram_cenb,
   output logic [AW-1:0]       ram_ab,
   output logic [DW-1:0]       ram_db
`ifdef NVDLA_DP_RAM_CTRL_STATS_EN
  ,output logic [31:0]         stat_rd_cnt,
   output logic [31:0]         stat_wr_cnt,
   output logic [31:0]         stat_coll_cnt,
   output logic [31:0]         stat_bubble_cnt
`endif
);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int SW = $clog2(WR_STARVE_MAX + 1);

   logic          inflight;
   logic [PW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic [DW-1:0] mem [RSP_DEPTH];
   logic [SW-1:0] starve;
   logic [CW:0]   occ;
   logic          wr_grant, rd_grant, collision, force_bubble, credit, push, pop;

   // A read in flight owns the capture cycle, so port B must stay idle then.
   always_comb begin
      wr_grant     = ~rst & bus.wr_valid & ~inflight;
      collision    = wr_grant & bus.rd_req_valid & (bus.rd_req_addr == bus.wr_addr);
      force_bubble = starve == SW'(WR_STARVE_MAX);
      push         = inflight;
      pop          = bus.rd_rsp_valid & bus.rd_rsp_ready;
      occ          = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
      credit       = occ < (CW+1)'(RSP_DEPTH);
      rd_grant     = ~rst & bus.rd_req_valid & credit & ~force_bubble & ~collision;
   end

   assign bus.wr_ready     = wr_grant;
   assign bus.rd_req_ready = rd_grant;
   assign bus.rd_rsp_valid = count != '0;
   assign bus.rd_rsp_data  = bus.rd_rsp_valid ? mem[rptr] : '0;

   assign ram_cena = ~rd_grant;
   assign ram_aa   = rd_grant ? bus.rd_req_addr : '0;
   assign ram_cenb = ~wr_grant;
   assign ram_ab   = wr_grant ? bus.wr_addr : '0;
   assign ram_db   = wr_grant ? bus.wr_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         starve   <= '0;
      end else begin
         inflight <= rd_grant;
         if (push) wptr <= wptr == PW'(RSP_DEPTH - 1) ? '0 : wptr + PW'(1);
         if (pop) rptr <= rptr == PW'(RSP_DEPTH - 1) ? '0 : rptr + PW'(1);
         count    <= count + CW'(push) - CW'(pop);
         starve   <= (bus.wr_valid & ~wr_grant) ? (force_bubble ? starve : starve + SW'(1)) : '0;
      end
   end

   always_ff @(posedge clk)
      if (push) mem[wptr] <= ram_qa;

   ast_rsp_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && count == CW'(RSP_DEPTH)));

`ifdef NVDLA_DP_RAM_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_cnt     <= '0;
         stat_wr_cnt     <= '0;
         stat_coll_cnt   <= '0;
         stat_bubble_cnt <= '0;
      end else begin
         if (rd_grant && ~&stat_rd_cnt) stat_rd_cnt <= stat_rd_cnt + 32'd1;
         if (wr_grant && ~&stat_wr_cnt) stat_wr_cnt <= stat_wr_cnt + 32'd1;
         if (collision && ~&stat_coll_cnt) stat_coll_cnt <= stat_coll_cnt + 32'd1;
         if (force_bubble && ~&stat_bubble_cnt) stat_bubble_cnt <= stat_bubble_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_nvdla_dp_ram_ctrl.sv
// tb_nvdla_dp_ram_ctrl: directed vector table, corner-case sequences and randomized traffic against a queue-based model.
module tb_nvdla_dp_ram_ctrl;
   localparam int AW = 8;
   localparam int DW = 64;
   localparam int D  = 2;
   localparam int SM = 4;
   localparam bit O  = 1'b0;
   localparam bit I  = 1'b1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nvdla_dp_ram_ctrl_if #(.AW(AW), .DW(DW)) bus ();
   logic          ram_cena, ram_cenb;
   logic [AW-1:0] ram_aa, ram_ab;
   logic [DW-1:0] ram_qa, ram_db;

   nvdla_dp_ram_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(D), .WR_STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .ram_cena(ram_cena), .ram_aa(ram_aa), .ram_qa(ram_qa),
      .ram_cenb(ram_cenb), .ram_ab(ram_ab), .ram_db(ram_db)
   );

   // RAM wrapper model; qa is garbage in any cycle not following a read.
   logic [DW-1:0] ram [2**AW] = '{default: '0};
   always @(posedge clk) begin
      ram_qa <= !ram_cena ? ram[ram_aa] : {$urandom, $urandom};
      if (!ram_cenb) ram[ram_ab] <= ram_db;
   end

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;

   function automatic void check(string n, logic [127:0] a, logic [127:0] e);
      chk_cnt++;
      if (a === e) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Reference model: accepted reads return memory contents at acceptance, two cycles later, in order.
   typedef struct { logic [DW-1:0] d; int t; } rsp_t;
   rsp_t          q[$];
   logic [DW-1:0] ref_mem [2**AW] = '{default: '0};
   logic          prev_rd = 1'b0;
   logic          rh, wh, pp;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         q.delete();
         prev_rd = 1'b0;
      end else begin
         rh = bus.rd_req_valid && bus.rd_req_ready;
         wh = bus.wr_valid && bus.wr_ready;
         pp = bus.rd_rsp_valid && bus.rd_rsp_ready;
         check("wr_ready_rule", bus.wr_ready, bus.wr_valid && !prev_rd);
         if (prev_rd) check("capture_cenb_high", ram_cenb, 1'b1);
         check("ram_a_port", {ram_cena, ram_aa}, {!rh, rh ? bus.rd_req_addr : 8'h00});
         check("ram_b_port", {ram_cenb, ram_ab, ram_db},
               {!wh, wh ? bus.wr_addr : 8'h00, wh ? bus.wr_data : 64'h0});
         check("rsp_valid", bus.rd_rsp_valid, q.size() > 0 && q[0].t <= cyc);
         if (pp && q.size() > 0) check("rsp_data", bus.rd_rsp_data, q[0].d);
         if (rh) check("rd_credit", (q.size() - int'(pp)) < D, 1'b1);
         if (rh && wh) check("rd_wr_same_addr", bus.rd_req_addr != bus.wr_addr, 1'b1);
         if (pp && q.size() > 0) void'(q.pop_front());
         if (rh) q.push_back('{ref_mem[bus.rd_req_addr], cyc + 2});
         if (wh) ref_mem[bus.wr_addr] = bus.wr_data;
         prev_rd = rh;
      end
   end

   typedef struct {
      bit wv; logic [AW-1:0] wa; logic [DW-1:0] wd;
      bit rv; logic [AW-1:0] ra; bit rr;
      bit e_wr; bit e_rd; bit e_v; logic [DW-1:0] e_d;
   } vec_t;
   vec_t tbl [23];

   task automatic drive(bit wv, logic [AW-1:0] wa, logic [DW-1:0] wd, bit rv, logic [AW-1:0] ra, bit rr);
      bus.wr_valid     = wv;
      bus.wr_addr      = wa;
      bus.wr_data      = wd;
      bus.rd_req_valid = rv;
      bus.rd_req_addr  = ra;
      bus.rd_rsp_ready = rr;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   bit whold, rhold;
   int got;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 23; i++) tbl[i] = '{default: '0};
      tbl[1]  = '{I, 8'h10, 64'hDEADBEEF_00000001, O, 8'h00, O, I, O, O, 64'h0};
      tbl[2]  = '{O, 8'h00, 64'h0, I, 8'h10, O, O, I, O, 64'h0};
      tbl[4]  = '{O, 8'h00, 64'h0, O, 8'h00, I, O, O, I, 64'hDEADBEEF_00000001};
      tbl[6]  = '{I, 8'h20, 64'h5, I, 8'h20, O, I, O, O, 64'h0};
      tbl[7]  = '{O, 8'h00, 64'h0, I, 8'h20, O, O, I, O, 64'h0};
      tbl[9]  = '{O, 8'h00, 64'h0, O, 8'h00, I, O, O, I, 64'h5};
      tbl[11] = '{I, 8'h21, 64'h7, I, 8'h10, O, I, I, O, 64'h0};
      tbl[12] = '{I, 8'h22, 64'h9, O, 8'h00, O, O, O, O, 64'h0};
      tbl[13] = '{I, 8'h22, 64'h9, O, 8'h00, I, I, O, I, 64'hDEADBEEF_00000001};
      tbl[15] = '{O, 8'h00, 64'h0, I, 8'h21, O, O, I, O, 64'h0};
      tbl[16] = '{O, 8'h00, 64'h0, I, 8'h22, O, O, I, O, 64'h0};
      tbl[17] = '{O, 8'h00, 64'h0, I, 8'h00, O, O, O, I, 64'h7};
      tbl[18] = '{O, 8'h00, 64'h0, I, 8'h00, O, O, O, I, 64'h7};
      tbl[19] = '{O, 8'h00, 64'h0, I, 8'h00, I, O, I, I, 64'h7};
      tbl[20] = '{O, 8'h00, 64'h0, O, 8'h00, I, O, O, I, 64'h9};
      tbl[21] = '{O, 8'h00, 64'h0, O, 8'h00, I, O, O, I, 64'h0};

      // Reset with requests pending: nothing may be granted.
      drive(I, 8'h55, 64'h1234, I, 8'h56, I);
      next();
      next();
      @(negedge clk);
      check("reset_outputs", {bus.wr_ready, bus.rd_req_ready, bus.rd_rsp_valid, ram_cena, ram_cenb},
            {O, O, O, I, I});
      check("reset_buses", {ram_aa, ram_ab, ram_db, bus.rd_rsp_data}, '0);
      next();
      rst = 1'b0;
      drive(O, 8'h00, 64'h0, O, 8'h00, O);

      foreach (tbl[i]) begin
         drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra, tbl[i].rr);
         @(negedge clk);
         check($sformatf("vec%0d_wr_ready", i), bus.wr_ready, tbl[i].e_wr);
         check($sformatf("vec%0d_rd_req_ready", i), bus.rd_req_ready, tbl[i].e_rd);
         check($sformatf("vec%0d_rsp_valid", i), bus.rd_rsp_valid, tbl[i].e_v);
         if (tbl[i].e_v) check($sformatf("vec%0d_rsp_data", i), bus.rd_rsp_data, tbl[i].e_d);
         next();
      end

      // Back-to-back reads: one response per cycle, in order.
      for (int i = 0; i < 16; i++) begin
         drive(I, 8'(i), {32'hC0DE0000, 32'(i) * 32'h01010101}, O, 8'h00, O);
         next();
      end
      for (int i = 0; i < 18; i++) begin
         drive(O, 8'h00, 64'h0, i < 16, 8'(i), I);
         @(negedge clk);
         if (i < 16) check("b2b_rd_ready", bus.rd_req_ready, I);
         if (i >= 2) check($sformatf("b2b_rsp%0d", i - 2), {bus.rd_rsp_valid, bus.rd_rsp_data},
                           {I, 32'hC0DE0000, 32'(i - 2) * 32'h01010101});
         next();
      end
      drive(O, 8'h00, 64'h0, O, 8'h00, I);
      next();

      // Write starved by continuous reads must get through via a forced bubble.
      drive(O, 8'h00, 64'h0, I, 8'h31, I);
      next();
      got = 0;
      for (int k = 1; k <= 8 && got == 0; k++) begin
         drive(I, 8'h30, 64'h5A5A_0000_1111_2222, I, 8'h31, I);
         @(negedge clk);
         if (bus.wr_ready) got = k;
         next();
      end
      check("starve_wr_latency", got >= 1 && got <= SM + 2, I);
      drive(O, 8'h00, 64'h0, O, 8'h00, I);
      next();
      next();
      got = 0;
      drive(O, 8'h00, 64'h0, I, 8'h30, I);
      for (int k = 0; k < 4 && got == 0; k++) begin
         @(negedge clk);
         if (bus.rd_req_ready) got = 1;
         next();
      end
      drive(O, 8'h00, 64'h0, O, 8'h00, I);
      for (int k = 0; k < 4 && got == 1; k++) begin
         @(negedge clk);
         if (bus.rd_rsp_valid) begin
            check("starve_readback", bus.rd_rsp_data, 64'h5A5A_0000_1111_2222);
            got = 2;
         end
         next();
      end
      if (got != 2) check("starve_readback_timeout", got, 2);

      // Reset mid-operation drops buffered and in-flight reads.
      drive(O, 8'h00, 64'h0, I, 8'h01, O);
      next();
      next();
      rst = 1'b1;
      drive(O, 8'h00, 64'h0, O, 8'h00, O);
      next();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("midreset_rsp_valid", bus.rd_rsp_valid, O);
         next();
      end

      // Randomized traffic on a small address window to provoke collisions and starvation.
      drive(O, 8'h00, 64'h0, O, 8'h00, O);
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         whold = bus.wr_valid && !bus.wr_ready;
         rhold = bus.rd_req_valid && !bus.rd_req_ready;
         next();
         if (!whold) begin
            bus.wr_valid = $urandom_range(0, 99) < 40;
            bus.wr_addr  = 8'($urandom_range(0, 7));
            bus.wr_data  = {$urandom, $urandom};
         end
         if (!rhold) begin
            bus.rd_req_valid = $urandom_range(0, 99) < (i < 1500 ? 60 : 95);
            bus.rd_req_addr  = 8'($urandom_range(0, 7));
         end
         bus.rd_rsp_ready = $urandom_range(0, 99) < 70;
      end
      drive(O, 8'h00, 64'h0, O, 8'h00, I);
      for (int k = 0; k < 20 && q.size() > 0; k++) next();
      check("drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/nvdla_dp_ram_ctrl.md
Name: nvdla_dp_ram_ctrl

Overview:
- Request-side controller that directly drives a 256x64 dual-port RAM wrapper: port A is the read port, port B is the write port, and chip enables are active-low.
- Accepts independent valid/ready write and read-request streams and issues them to the RAM.
- Captures read data into a small response FIFO.
- Enforces the wrapper's hazard rule: QA is valid only when CENB is high in the capture cycle.

Parameters:
- AW, 8, address width; RAM depth is 2**AW.
- DW, 64, data width.
- RSP_DEPTH, 2, response FIFO entries; minimum 2.
- WR_STARVE_MAX, 4, number of consecutive blocked write cycles before a read bubble is forced.

Ports:
- clk  in  1  single clock; also drives the RAM's CLKA/CLKB.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted when valid&ready.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- rd_req_valid  in  1  read request valid.
- rd_req_ready  out  1  read request accepted when valid&ready.
- rd_req_addr  in  AW  read address.
- rd_rsp_valid  out  1  response FIFO non-empty.
- rd_rsp_ready  in  1  response pop.
- rd_rsp_data  out  DW  head of response FIFO.
- ram_cena  out  1  RAM read enable, active-low.
- ram_aa  out  AW  RAM read address.
- ram_qa  in  DW  RAM read data, valid the cycle after ram_cena low.
- ram_cenb  out  1  RAM write enable, active-low.
- ram_ab  out  AW  RAM write address.
- ram_db  out  DW  RAM write data.

Behaviour:
- Reset (synchronous, active-high):
  - ram_cena=1, ram_cenb=1, ram_aa=0, ram_ab=0, ram_db=0.
  - wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0.
  - FIFO empty, in-flight flag clear, starvation counter=0.
- RAM port drive:
  - RAM port signals are combinational from the grant decision; ram_cena = ~rd_grant, ram_cenb = ~wr_grant.
  - Address and data pass through from the granted request. When not granted, addresses and data hold 0.
- Read pipeline:
  - A read accepted in cycle T sets the `inflight` register.
  - In cycle T+1, ram_qa is pushed into the FIFO.
  - rd_rsp_valid rises in cycle T+2. Minimum latency is 2 cycles; full throughput is 1 read/cycle.
- Capture-cycle rule: while `inflight`=1, wr_grant=0 (CENB stays high).
- Read credit: rd_req_ready requires count + inflight - pop < RSP_DEPTH, where pop = rd_rsp_valid & rd_rsp_ready.
- Write grant: wr_grant = wr_valid & ~inflight.
- Read grant: rd_grant = rd_req_valid & credit & ~force_bubble & ~collision.
- Collision:
  - Defined as wr_grant & rd_req_valid & (rd_req_addr == wr_addr).
  - The write wins; the read stalls one cycle and returns the new data.
  - A read and a write to different addresses are granted in the same cycle.
- Starvation counter:
  - Increments each cycle wr_valid=1 and wr_ready=0; clears on a write handshake or when wr_valid=0.
  - Saturates at WR_STARVE_MAX.
  - force_bubble = (counter == WR_STARVE_MAX): no read is granted that cycle, so the next cycle has inflight=0 and the write proceeds.
- Response FIFO:
  - Circular buffer with wrapping pointers.
  - Push and pop in the same cycle leave count unchanged.
  - Overflow is impossible by credit. An assertion fires on push while full.
- Reset mid-operation: the in-flight read is discarded and FIFO contents are dropped; the RAM contents are untouched.
- Requestors hold request fields stable while valid=1 and ready=0.

Optional Feature:
- Macro: NVDLA_DP_RAM_CTRL_STATS_EN.
- When defined, adds 32-bit saturating counters, cleared by rst:
  - stat_rd_cnt (read grants)
  - stat_wr_cnt (write grants)
  - stat_coll_cnt (collision stalls)
  - stat_bubble_cnt (forced bubbles)
- These are exposed as outputs stat_rd_cnt, stat_wr_cnt, stat_coll_cnt, stat_bubble_cnt.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Reset then idle: ram_cena=1, ram_cenb=1, rd_rsp_valid=0 and all outputs 0 after one rst cycle; wr_ready=1 once wr_valid is asserted.
2. Write addr 0x10 data 0xDEADBEEF_00000001, then read 0x10 -> rd_rsp_data=0xDEADBEEF_00000001 with rd_rsp_valid exactly 2 cycles after the read handshake.
3. Back-to-back reads 0x00..0x0F with rd_rsp_ready=1 -> 16 responses on 16 consecutive cycles, in order.
4. Same-cycle write and read to 0x20 (old data 0x0, new 0x5) -> write granted, read stalled 1 cycle, response 0x5.
5. Continuous reads with a pending write to 0x30 and WR_STARVE_MAX=4 -> write granted within 6 cycles; no capture cycle ever has ram_cenb=0.
6. rd_rsp_ready=0 with RSP_DEPTH=2 -> exactly 2 reads accepted, then rd_req_ready=0. Release -> data in order, then new reads accepted.
